// File: rtl/mem_lock_arbiter.sv
// mem_lock_arbiter: round-robin main-memory arbiter plus a 2^LW-slot hardware mutex table shared by C cores.
// Latency: memory grant, strobes, address/data and lock acks are all registered, 1 cycle after the request is seen.
// Backpressure: none; a core holds its request until it sees its grant/ack pulse, and losing cores simply retry.
module mem_lock_arbiter #(
   parameter int C  = 8,
   parameter int LW = 4,
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush,
   input  logic [C-1:0]         main_mem_read_request,
   input  logic [C-1:0]         main_mem_write_request,
   input  logic [C-1:0][AW-1:0] main_mem_read_adr,
   input  logic [C-1:0][AW-1:0] main_mem_write_adr,
   input  logic [C-1:0][DW-1:0] main_mem_write_dat,
   output logic [C-1:0]         main_mem_ac,
   output logic [AW-1:0]        mem_adr,
   output logic [DW-1:0]        mem_wdat,
   output logic                 mem_we,
   output logic                 mem_re,
   input  logic [C-1:0][LW-1:0] lock_adr,
   input  logic [C-1:0]         lock_en,
   input  logic [C-1:0]         unlock_en,
   output logic [C-1:0]         lock_ac,
   output logic [(1<<LW)-1:0]   lock_held,
   output logic                 lock_err
);

   localparam int NS = 1 << LW;
   localparam int PW = (C > 1) ? $clog2(C) : 1;

   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         lk_ptr;
   logic [NS-1:0]         held_q;
   logic [NS-1:0][PW-1:0] owner_q;

   // Pointer advance with wrap at C (C need not be a power of two)
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(C - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [C-1:0] mem_req;
   logic         mem_found;
   logic [PW-1:0] mem_win;
   logic [PW:0]  mem_idx;

   assign mem_req = main_mem_read_request | main_mem_write_request;

   // Memory winner: first requester scanning upward from rr_ptr, wrapping modulo C
   always_comb begin
      mem_found = 1'b0;
      mem_win   = '0;
      mem_idx   = '0;
      for (int k = 0; k < C; k++) begin
         mem_idx = {1'b0, rr_ptr} + (PW+1)'(k);
         if (mem_idx >= (PW+1)'(C)) mem_idx = mem_idx - (PW+1)'(C);
         if (!mem_found && mem_req[mem_idx[PW-1:0]]) begin
            mem_found = 1'b1;
            mem_win   = mem_idx[PW-1:0];
         end
      end
   end

   logic [C-1:0]  lk_elig;
   logic [C-1:0]  lk_ack_base;
   logic [NS-1:0] held_clr;
   logic          err_nxt;

   // Releases (all in parallel) and re-acquire acks, judged on the pre-edge table; unlock beats lock per core
   always_comb begin
      lk_elig     = '0;
      lk_ack_base = '0;
      held_clr    = '0;
      err_nxt     = lock_err;
      for (int i = 0; i < C; i++) begin
         if (unlock_en[i]) begin
            lk_ack_base[i] = 1'b1;
            if (held_q[lock_adr[i]] && (owner_q[lock_adr[i]] == PW'(i)))
               held_clr[lock_adr[i]] = 1'b1;
            else
               err_nxt = 1'b1;
         end else if (lock_en[i]) begin
            if (!held_q[lock_adr[i]])
               lk_elig[i] = 1'b1;
            else if (owner_q[lock_adr[i]] == PW'(i))
               lk_ack_base[i] = 1'b1;
         end
      end
   end

   logic          lk_found;
   logic [PW-1:0] lk_win;
   logic [PW:0]   lk_idx;
   logic [C-1:0]  lk_ack_nxt;
   logic [NS-1:0] held_nxt;
   logic [NS-1:0][PW-1:0] owner_nxt;

   // One new acquisition per cycle, round-robin from lk_ptr; a slot freed this cycle is not re-granted until next
   always_comb begin
      lk_found   = 1'b0;
      lk_win     = '0;
      lk_idx     = '0;
      for (int k = 0; k < C; k++) begin
         lk_idx = {1'b0, lk_ptr} + (PW+1)'(k);
         if (lk_idx >= (PW+1)'(C)) lk_idx = lk_idx - (PW+1)'(C);
         if (!lk_found && lk_elig[lk_idx[PW-1:0]]) begin
            lk_found = 1'b1;
            lk_win   = lk_idx[PW-1:0];
         end
      end
      held_nxt   = held_q & ~held_clr;
      owner_nxt  = owner_q;
      lk_ack_nxt = lk_ack_base;
      if (lk_found) begin
         held_nxt[lock_adr[lk_win]]  = 1'b1;
         owner_nxt[lock_adr[lk_win]] = lk_win;
         lk_ack_nxt[lk_win]          = 1'b1;
      end
   end

   // Architectural state and registered outputs; flush clears everything like reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_mem_ac <= '0;
         mem_adr     <= '0;
         mem_wdat    <= '0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         rr_ptr      <= '0;
         lk_ptr      <= '0;
         lock_ac     <= '0;
         held_q      <= '0;
         owner_q     <= '0;
         lock_err    <= 1'b0;
      end else if (flush) begin
         main_mem_ac <= '0;
         mem_adr     <= '0;
         mem_wdat    <= '0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         rr_ptr      <= '0;
         lk_ptr      <= '0;
         lock_ac     <= '0;
         held_q      <= '0;
         owner_q     <= '0;
         lock_err    <= 1'b0;
      end else begin
         if (mem_found) begin
            main_mem_ac <= C'(1) << mem_win;
            mem_adr     <= main_mem_write_request[mem_win] ? main_mem_write_adr[mem_win]
                                                           : main_mem_read_adr[mem_win];
            mem_wdat    <= main_mem_write_dat[mem_win];
            mem_we      <= main_mem_write_request[mem_win];
            mem_re      <= !main_mem_write_request[mem_win];
            rr_ptr      <= wrap_inc(mem_win);
         end else begin
            main_mem_ac <= '0;
            mem_adr     <= '0;
            mem_wdat    <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
         end
         lock_ac  <= lk_ack_nxt;
         held_q   <= held_nxt;
         owner_q  <= owner_nxt;
         lock_err <= err_nxt;
         if (lk_found) lk_ptr <= wrap_inc(lk_win);
      end
   end

   assign lock_held = held_q;

endmodule
